// File: rtl/vga_timing_generator.sv
// VGA/LCD raster engine: h/v counters, pixel request stage, and a sync/blank
// delay line that re-aligns the pins with colour returned PIPE_LAT cycles later.
module vga_timing_generator #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int COLOR_W  = 10,
  parameter int PIPE_LAT = 2,
  parameter int X_W      = 11,
  parameter int Y_W      = 10
) (
  input  logic                   CLOCK_PIX,
  input  logic                   RESET_N,
  input  logic                   ENABLE,
  output logic                   REQ,
  output logic [X_W-1:0]         X,
  output logic [Y_W-1:0]         Y,
  output logic                   LINE_START,
  output logic                   FRAME_START,
  output logic [15:0]            FRAME_CNT,
  input  logic [3*COLOR_W-1:0]   RGB_IN,
  output logic                   VGA_HSYNC,
  output logic                   VGA_VSYNC,
  output logic                   VGA_BLANK,
  output logic                   VGA_SYNC,
  output logic [COLOR_W-1:0]     VGA_R,
  output logic [COLOR_W-1:0]     VGA_G,
  output logic [COLOR_W-1:0]     VGA_B
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [31:0] H_LAST   = 32'(H_TOTAL - 1);
  localparam logic [31:0] V_LAST   = 32'(V_TOTAL - 1);
  localparam logic [31:0] H_ACT    = 32'(H_ACTIVE);
  localparam logic [31:0] V_ACT    = 32'(V_ACTIVE);
  localparam logic [31:0] HS_START = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] HS_END   = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] VS_START = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] VS_END   = 32'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e          state_q, state_d;
  logic [X_W-1:0]  h_q, h_d;
  logic [Y_W-1:0]  v_q, v_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic [31:0]     h_ext, v_ext;
  logic            run;

  logic            req_q, req_d;
  logic [X_W-1:0]  x_q;
  logic [Y_W-1:0]  y_q;
  logic            line_start_q, frame_start_q;
  logic            hs_raw_q, hs_raw_d;
  logic            vs_raw_q, vs_raw_d;

  logic            hs_dly, vs_dly, de_dly;
  logic            vga_hs_q, vga_vs_q, vga_blank_q;
  logic [COLOR_W-1:0] vga_r_q, vga_g_q, vga_b_q;

  // Widened copies so comparisons against mode constants never truncate.
  assign h_ext = 32'(h_q);
  assign v_ext = 32'(v_q);
  assign run   = (state_q == S_RUN);

  // Next-state logic: counters advance in RUN; stopping only at frame end.
  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    v_d         = v_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      S_IDLE: begin
        h_d = '0;
        v_d = '0;
        if (ENABLE) state_d = S_RUN;
      end
      S_RUN: begin
        if (h_ext == H_LAST) begin
          h_d = '0;
          if (v_ext == V_LAST) begin
            v_d         = '0;
            frame_cnt_d = frame_cnt_q + 16'd1;
            if (!ENABLE) state_d = S_IDLE;
          end else begin
            v_d = Y_W'(v_ext + 32'd1);
          end
        end else begin
          h_d = X_W'(h_ext + 32'd1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counter and frame-count registers.
  always_ff @(posedge CLOCK_PIX or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= S_IDLE;
      h_q         <= '0;
      v_q         <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      v_q         <= v_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Raw timing decoded from the counters; all inactive while idle.
  always_comb begin
    req_d    = run && (h_ext < H_ACT) && (v_ext < V_ACT);
    hs_raw_d = run && (h_ext >= HS_START) && (h_ext < HS_END);
    vs_raw_d = run && (v_ext >= VS_START) && (v_ext < VS_END);
  end

  // Request stage: one cycle behind the counters; X/Y hold outside active area.
  always_ff @(posedge CLOCK_PIX or negedge RESET_N) begin
    if (!RESET_N) begin
      req_q         <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      hs_raw_q      <= 1'b0;
      vs_raw_q      <= 1'b0;
    end else begin
      req_q         <= req_d;
      line_start_q  <= req_d && (h_ext == 32'd0);
      frame_start_q <= req_d && (h_ext == 32'd0) && (v_ext == 32'd0);
      hs_raw_q      <= hs_raw_d;
      vs_raw_q      <= vs_raw_d;
      if (req_d) begin
        x_q <= h_q;
        y_q <= v_q;
      end
    end
  end

  generate
    if (PIPE_LAT == 0) begin : g_nopipe
      assign hs_dly = hs_raw_q;
      assign vs_dly = vs_raw_q;
      assign de_dly = req_q;
    end else begin : g_pipe
      logic [2:0] sr_q [PIPE_LAT];
      // Delay line {hs, vs, de} matching the pixel source latency.
      always_ff @(posedge CLOCK_PIX or negedge RESET_N) begin
        if (!RESET_N) begin
          for (int i = 0; i < PIPE_LAT; i++) sr_q[i] <= 3'b000;
        end else begin
          sr_q[0] <= {hs_raw_q, vs_raw_q, req_q};
          for (int i = 1; i < PIPE_LAT; i++) sr_q[i] <= sr_q[i-1];
        end
      end
      assign hs_dly = sr_q[PIPE_LAT-1][2];
      assign vs_dly = sr_q[PIPE_LAT-1][1];
      assign de_dly = sr_q[PIPE_LAT-1][0];
    end
  endgenerate

  // Pin register: colour gated by delayed enable, syncs mapped to polarity.
  always_ff @(posedge CLOCK_PIX or negedge RESET_N) begin
    if (!RESET_N) begin
      vga_hs_q    <= ~HS_POL;
      vga_vs_q    <= ~VS_POL;
      vga_blank_q <= 1'b0;
      vga_r_q     <= '0;
      vga_g_q     <= '0;
      vga_b_q     <= '0;
    end else begin
      vga_hs_q    <= hs_dly ? HS_POL : ~HS_POL;
      vga_vs_q    <= vs_dly ? VS_POL : ~VS_POL;
      vga_blank_q <= de_dly;
      vga_r_q     <= de_dly ? RGB_IN[3*COLOR_W-1 -: COLOR_W] : '0;
      vga_g_q     <= de_dly ? RGB_IN[2*COLOR_W-1 -: COLOR_W] : '0;
      vga_b_q     <= de_dly ? RGB_IN[COLOR_W-1 -: COLOR_W]   : '0;
    end
  end

  assign REQ         = req_q;
  assign X           = x_q;
  assign Y           = y_q;
  assign LINE_START  = line_start_q;
  assign FRAME_START = frame_start_q;
  assign FRAME_CNT   = frame_cnt_q;
  assign VGA_HSYNC   = vga_hs_q;
  assign VGA_VSYNC   = vga_vs_q;
  assign VGA_BLANK   = vga_blank_q;
  assign VGA_SYNC    = 1'b0;
  assign VGA_R       = vga_r_q;
  assign VGA_G       = vga_g_q;
  assign VGA_B       = vga_b_q;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: a reduced mode A (24x11, PIPE_LAT=2) under a
// coordinate/pixel scoreboard with sync monitors, and the small mode B
// (12x7, PIPE_LAT=0, HS_POL=1) for timing and asynchronous reset.
module tb_vga_timing_generator;

  localparam int HT_A    = 24;
  localparam int FRAME_A = 264;
  localparam int HA_A    = 16;
  localparam int VA_A    = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [29:0] pix(input int x, input int y);
    return {10'(x), 10'(y), 10'(x ^ y)};
  endfunction

  // ---------------- mode A ----------------
  logic        a_rst_n = 1'b1;
  logic        a_en = 1'b0;
  logic        a_req, a_ls, a_fs, a_hsync, a_vsync, a_blank, a_sync;
  logic [4:0]  a_x;
  logic [3:0]  a_y;
  logic [15:0] a_fc;
  logic [29:0] a_rgb_in;
  logic [9:0]  a_r, a_g, a_b;
  logic [29:0] a_p1 = '1;
  logic [29:0] a_p2 = '1;

  vga_timing_generator #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(10), .PIPE_LAT(2), .X_W(5), .Y_W(4)
  ) dut_a (
    .CLOCK_PIX(clk), .RESET_N(a_rst_n), .ENABLE(a_en),
    .REQ(a_req), .X(a_x), .Y(a_y), .LINE_START(a_ls), .FRAME_START(a_fs),
    .FRAME_CNT(a_fc), .RGB_IN(a_rgb_in),
    .VGA_HSYNC(a_hsync), .VGA_VSYNC(a_vsync), .VGA_BLANK(a_blank), .VGA_SYNC(a_sync),
    .VGA_R(a_r), .VGA_G(a_g), .VGA_B(a_b)
  );

  // Pixel source with 2-cycle latency; returns all-ones for non-requests.
  always @(posedge clk) begin
    a_p1 <= a_req ? pix(int'(a_x), int'(a_y)) : '1;
    a_p2 <= a_p1;
  end
  assign a_rgb_in = a_p2;

  int          exp_x[$];
  int          exp_y[$];
  logic [29:0] exp_pix[$];

  task automatic push_frames(input int n);
    for (int f = 0; f < n; f++)
      for (int y = 0; y < VA_A; y++)
        for (int x = 0; x < HA_A; x++) begin
          exp_x.push_back(x);
          exp_y.push_back(y);
          exp_pix.push_back(pix(x, y));
        end
  endtask

  // Request monitor: each REQ must be the next raster coordinate.
  always @(negedge clk) begin
    int ex, ey;
    if (a_req) begin
      chk("req_queue_nonempty", 64'(exp_x.size() > 0), 1);
      if (exp_x.size() > 0) begin
        ex = exp_x.pop_front();
        ey = exp_y.pop_front();
        chk("req_x", a_x, ex);
        chk("req_y", a_y, ey);
        chk("line_start", a_ls, ex == 0);
        chk("frame_start", a_fs, ex == 0 && ey == 0);
      end
    end else if (a_ls | a_fs) begin
      chk("start_without_req", {a_ls, a_fs}, 0);
    end
  end

  // Pixel monitor: colour at the pins while unblanked, zero while blanked.
  int blank_len = 0;
  logic blank_prev = 1'b0;
  always @(negedge clk) begin
    if (a_blank) begin
      chk("pix_queue_nonempty", 64'(exp_pix.size() > 0), 1);
      if (exp_pix.size() > 0) chk("pin_rgb", {a_r, a_g, a_b}, exp_pix.pop_front());
      blank_len++;
    end else begin
      chk("rgb_zero_blanked", {a_r, a_g, a_b}, 0);
      if (blank_prev) chk("blank_width", blank_len, HA_A);
      blank_len = 0;
    end
    blank_prev = a_blank;
  end

  // Sync monitor: widths, periods and offsets of the sync pins.
  bit   sync_track = 1'b0;
  int   ls_cyc = -100000, fs_cyc = -100000, hf_cyc = 0;
  bit   hf_valid = 1'b0, fs_valid = 1'b0;
  logic hs_prev = 1'b1, vs_prev = 1'b1;
  int   hs_len = 0, vs_len = 0;
  always @(negedge clk) begin
    if (!sync_track) begin
      hf_valid = 1'b0;
      fs_valid = 1'b0;
    end
    if (a_ls) ls_cyc = cyc;
    if (a_fs) begin
      if (fs_valid) chk("frame_period", cyc - fs_cyc, FRAME_A);
      fs_cyc   = cyc;
      fs_valid = sync_track;
    end
    if (!a_hsync) begin
      if (hs_prev) begin
        if (cyc - ls_cyc < HT_A) chk("hs_after_line_start", cyc - ls_cyc, 21);
        if (hf_valid) chk("line_period", cyc - hf_cyc, HT_A);
        hf_cyc   = cyc;
        hf_valid = sync_track;
        hs_len   = 1;
      end else hs_len++;
    end else if (!hs_prev) chk("hs_width", hs_len, 3);
    hs_prev = a_hsync;
    if (!a_vsync) begin
      if (vs_prev) begin
        chk("vs_after_frame_start", cyc - fs_cyc, 171);
        vs_len = 1;
      end else vs_len++;
    end else if (!vs_prev) chk("vs_width", vs_len, 48);
    vs_prev = a_vsync;
  end

  task automatic wait_fc_a(input int target, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (a_fc == 16'(target)) break;
      @(negedge clk);
    end
    chk("frame_cnt_a", a_fc, target);
  endtask

  task automatic idle_pins_a(input int n, input int fc);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_req", a_req, 0);
      chk("idle_pins", {a_hsync, a_vsync, a_blank, a_sync}, 4'b1100);
      chk("idle_fc", a_fc, fc);
    end
  endtask

  // ---------------- mode B ----------------
  logic        b_rst_n = 1'b1;
  logic        b_en = 1'b0;
  logic        b_req, b_ls, b_fs, b_hsync, b_vsync, b_blank, b_sync;
  logic [3:0]  b_x;
  logic [2:0]  b_y;
  logic [15:0] b_fc;
  logic [29:0] b_rgb_in;
  logic [9:0]  b_r, b_g, b_b;

  vga_timing_generator #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .COLOR_W(10), .PIPE_LAT(0), .X_W(4), .Y_W(3)
  ) dut_b (
    .CLOCK_PIX(clk), .RESET_N(b_rst_n), .ENABLE(b_en),
    .REQ(b_req), .X(b_x), .Y(b_y), .LINE_START(b_ls), .FRAME_START(b_fs),
    .FRAME_CNT(b_fc), .RGB_IN(b_rgb_in),
    .VGA_HSYNC(b_hsync), .VGA_VSYNC(b_vsync), .VGA_BLANK(b_blank), .VGA_SYNC(b_sync),
    .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b)
  );

  assign b_rgb_in = b_req ? pix(int'(b_x), int'(b_y)) : '1;

  // ---------------- stimulus ----------------
  initial begin
    int c1, n;
    logic prev;
    bit found;

    #1;
    a_rst_n = 1'b0;
    b_rst_n = 1'b0;
    @(negedge clk);
    chk("rst_req", a_req, 0);
    chk("rst_pins", {a_hsync, a_vsync, a_blank, a_r, a_g, a_b}, {3'b110, 30'd0});
    chk("rst_xy_fc", {a_x, a_y, a_fc}, 0);
    repeat (3) @(negedge clk);
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;

    // Idle with ENABLE low.
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      chk("idle0_req", a_req, 0);
      chk("idle0_pins", {a_hsync, a_vsync, a_blank, a_sync, a_r, a_g, a_b}, {4'b1100, 30'd0});
      chk("idle0_fc", a_fc, 0);
    end

    // Continuous run, then stop requested mid-frame 4.
    push_frames(4);
    sync_track = 1'b1;
    a_en = 1'b1;
    @(negedge clk);
    chk("start_req_lat1", a_req, 0);
    @(negedge clk);
    chk("start_req_lat2", {a_req, a_fs}, 2'b11);
    wait_fc_a(3, 4 * FRAME_A);
    repeat (3 * HT_A) @(negedge clk);
    a_en = 1'b0;
    wait_fc_a(4, FRAME_A + 10);
    sync_track = 1'b0;
    repeat (4) @(negedge clk);
    idle_pins_a(50, 4);
    chk("queue_empty_stop", exp_x.size() + exp_pix.size(), 0);

    // Restart; ENABLE glitches low mid-frame, high again before frame end.
    push_frames(2);
    sync_track = 1'b1;
    a_en = 1'b1;
    @(negedge clk);
    chk("restart_req_lat1", a_req, 0);
    @(negedge clk);
    chk("restart_req_lat2", {a_req, a_fs, a_x, a_y}, {2'b11, 9'd0});
    repeat (4 * HT_A) @(negedge clk);
    a_en = 1'b0;
    repeat (3 * HT_A) @(negedge clk);
    a_en = 1'b1;
    wait_fc_a(5, FRAME_A + 10);
    a_en = 1'b0;
    wait_fc_a(6, FRAME_A + 10);
    sync_track = 1'b0;
    repeat (4) @(negedge clk);
    idle_pins_a(30, 6);
    chk("queue_empty_end", exp_x.size() + exp_pix.size(), 0);

    // Mode B: frame/line timing with active-high HSYNC.
    chk("b_idle_pins", {b_hsync, b_vsync, b_blank, b_sync}, 4'b0100);
    b_en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      found = b_fs;
    end
    chk("b_first_fs", found, 1);
    c1 = cyc;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      found = b_fs;
    end
    chk("b_frame_period", cyc - c1, 84);
    prev = b_hsync;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      found = !prev && b_hsync;
      prev  = b_hsync;
    end
    chk("b_hs_rise_seen", found, 1);
    c1 = cyc;
    n = 0;
    for (int i = 0; i < 20 && b_hsync; i++) begin
      n++;
      @(negedge clk);
    end
    chk("b_hs_width", n, 2);
    prev = b_hsync;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      found = !prev && b_hsync;
      prev  = b_hsync;
    end
    chk("b_line_period", cyc - c1, 12);

    // Asynchronous reset in the middle of an active line.
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      found = b_blank;
    end
    chk("b_active_before_rst", {b_blank, 1'(b_fc != 16'd0)}, 2'b11);
    #1 b_rst_n = 1'b0;
    #1;
    chk("b_rst_sync_pins", {b_hsync, b_vsync, b_blank, b_sync}, 4'b0100);
    chk("b_rst_rgb", {b_r, b_g, b_b}, 0);
    chk("b_rst_req", {b_req, b_ls, b_fs}, 0);
    chk("b_rst_xy_fc", {b_x, b_y, b_fc}, 0);
    repeat (2) @(negedge clk);
    b_rst_n = 1'b1;
    @(negedge clk);
    chk("b_restart_lat1", b_req, 0);
    @(negedge clk);
    chk("b_restart_lat2", {b_req, b_fs, b_ls}, 3'b111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_generator.md
# vga_timing_generator

Parametrised VGA/LCD raster engine: the next-generation core behind the board-level VGA top, driving the DE2-series video DAC from a single pixel clock. It generates horizontal and vertical timing from per-mode porch/sync parameters and issues pixel requests (X, Y) to a user pixel source of known latency. It re-aligns HSYNC, VSYNC and BLANK with the returned colour, and supports clean start/stop at frame boundaries.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch, in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch / sync / back porch, in lines
- HS_POL / VS_POL, 0 / 0, asserted sync level (0 = active-low)
- COLOR_W, 10, bits per colour channel
- PIPE_LAT, 2, RGB_IN latency after REQ, in cycles (0..15)
- X_W / Y_W, 11 / 10, coordinate widths; H_TOTAL ≤ 2^X_W and V_TOTAL ≤ 2^Y_W are required
- Ports:
- CLOCK_PIX in 1: pixel clock; all logic on its rising edge
- RESET_N in 1: asynchronous, active-low reset
- ENABLE in 1: run request; sampled at frame end and in IDLE
- REQ out 1: pixel request valid
- X out X_W: requested column
- Y out Y_W: requested row
- LINE_START out 1: one-cycle pulse with every request at X=0
- FRAME_START out 1: one-cycle pulse with the request at (0,0)
- FRAME_CNT out 16: completed-frame count; wraps at 65535→0
- RGB_IN in 3*COLOR_W: {R,G,B} for the request issued PIPE_LAT cycles earlier
- VGA_HSYNC, VGA_VSYNC out 1: sync pins
- VGA_BLANK out 1: active-low blank (0 = blanked)
- VGA_SYNC out 1: sync-on-green; constant 0
- VGA_R, VGA_G, VGA_B out COLOR_W: colour pins

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL is defined the same way.
- Counters: h ∈ [0, H_TOTAL-1] and v ∈ [0, V_TOTAL-1]. Region order is active, FP, sync, BP, with counter 0 as the first active pixel.
- h increments every RUN cycle. At h=H_TOTAL-1, h wraps to 0 and v increments. v wraps at V_TOTAL-1.
- States:
  - IDLE: counters held at 0.
  - RUN: counters advance.
  - Transition IDLE→RUN when ENABLE=1. The first RUN cycle issues (0,0) on the next clock.
  - At RUN, h=H_TOTAL-1, v=V_TOTAL-1: FRAME_CNT increments. The engine then stays in RUN if ENABLE=1, otherwise goes to IDLE.
  - ENABLE falling mid-frame has no effect until the frame completes.
- Request stage (registered, 1 cycle after counters):
  - REQ = RUN & h<H_ACTIVE & v<V_ACTIVE.
  - X=h, Y=v when REQ; otherwise X and Y hold their last values.
- Raw timing signals:
  - hs_raw asserted for H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC.
  - vs_raw asserted for V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC, over whole lines.
  - de_raw = REQ.
  - In IDLE all three are deasserted.
- Alignment: hs_raw, vs_raw and de_raw pass through a PIPE_LAT-deep shift register, then an output register.
- Output register:
  - VGA_R/G/B = RGB_IN when delayed de is set, else 0.
  - VGA_BLANK = delayed de.
  - VGA_HSYNC = HS_POL when delayed hs is asserted, else ~HS_POL. VGA_VSYNC follows the same rule with VS_POL.
- Reset (asynchronous, immediate):
  - State IDLE; h, v, X, Y, FRAME_CNT = 0.
  - REQ, LINE_START, FRAME_START = 0.
  - Shift register holds the inactive pattern.
  - VGA_HSYNC = ~HS_POL, VGA_VSYNC = ~VS_POL, VGA_BLANK = 0, RGB pins = 0, VGA_SYNC = 0.

## Timing
- Request latency: counter value → REQ/X/Y in 1 cycle.
- Pins: REQ → VGA_* in PIPE_LAT+1 cycles. RGB_IN is sampled exactly PIPE_LAT cycles after its REQ.
- Line period: H_TOTAL cycles. Frame period: H_TOTAL·V_TOTAL cycles. Both have zero jitter in continuous RUN.
- Stop: the pins reach the idle pattern PIPE_LAT+1 cycles after the last BP cycle. No partial frames are ever emitted.
- ENABLE reasserted in the same cycle as frame end means continuous RUN, with no gap cycle.

## Test plan
- Reset, defaults, ENABLE=0 for 1000 cycles -> HSYNC=1, VSYNC=1, BLANK=0, RGB=0, REQ=0, FRAME_CNT=0 throughout.
- ENABLE=1 -> FRAME_START coincides with the first REQ at X=0,Y=0. REQ is high for 640 consecutive cycles per line at 800-cycle period. HSYNC is low for 96 cycles, starting 656+3 cycles after each LINE_START.
- Continuous run, 3 frames -> VSYNC low for exactly 1600 cycles starting on line 490. FRAME_START period is 420000 cycles. FRAME_CNT reads 3.
- Model source returns {X[9:0],Y[9:0],X^Y} 2 cycles after REQ -> each pin pixel equals its model value. BLANK is high exactly 640 cycles per active line. RGB is 0 on all blanked cycles.
- Drop ENABLE at line 100 -> frame completes through v=524, FRAME_CNT increments once, pins go idle. Reassert ENABLE -> REQ for (0,0) 2 cycles later.
- Small mode (H 8/1/2/1, V 4/1/1/1, PIPE_LAT=0, HS_POL=1) with RESET_N pulsed low mid-line -> line period 12, frame period 84, HSYNC high for 2 cycles. Outputs reach reset values without a clock edge.
